intf_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream interface instance between `N_REQ` requesters. The requesters are typically generated from an interface-array `generate` loop. Each requester presents a request with a data word. The arbiter grants one requester at a time, forwards its word on a single valid/ready output, and returns a one-cycle acknowledge. It sits between the per-index generate blocks and the single shared consumer.

---
 rtl/intf_arb_pkg.sv | 17 +
 rtl/intf_rr_arbiter_rr_pick.sv | 28 ++
 rtl/intf_rr_arbiter.sv | 97 +++++++++
 tb/tb_intf_rr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/intf_arb_pkg.sv
// Shared types, limits and helpers for the round-robin interface arbiter.
// Imported by intf_rr_arbiter; the optional lock feature is selected there via INTF_ARB_LOCK_EN.
package intf_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_REQ = 16;

    // Next index after idx in a ring of n entries.
    function automatic int arb_wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/intf_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req scanning upward
// from ptr, wrapping from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/intf_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output between N_REQ requesters.
// Define INTF_ARB_LOCK_EN to let a completing requester holding req_lock keep priority.
module intf_rr_arbiter
    import intf_arb_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int DATA_W = 8,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        ack,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_src,
    input  logic                    out_ready
);

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ) begin : g_bad_n_req
        $error("intf_rr_arbiter: N_REQ must be within 2..16");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  out_src_q, out_src_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              lock_hold;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef INTF_ARB_LOCK_EN
    assign lock_hold = req_lock[out_src_q];
`else
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
    assign lock_hold       = 1'b0;
`endif

    // Requests are only sampled in IDLE; a BUSY word is frozen until the consumer takes it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        ack        = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    out_src_d  = pick_idx;
                    out_data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (out_ready) begin
                    ack[out_src_q] = 1'b1;
                    ptr_d   = lock_hold ? out_src_q
                                        : IDX_W'(arb_wrap_inc(int'(out_src_q), N_REQ));
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            out_src_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_src_q  <= out_src_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = (state_q == ARB_BUSY);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// Self-checking bench for intf_rr_arbiter (N_REQ=4, DATA_W=8): a vector table
// plus hand-written sequences for fairness, backpressure, async reset and lock.
module tb_intf_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;
    localparam logic [31:0] BASE_DATA = 32'h3CA5_2110;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        ack;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_src;
    logic                    out_ready;

    int vec_count  = 0;
    int miss_count = 0;

    logic [7:0] word_of [4] = '{8'h10, 8'h21, 8'hA5, 8'h3C};

    typedef struct {
        logic [3:0] req;
        logic       out_ready;
        logic       exp_valid;
        logic [3:0] exp_ack;
        logic [1:0] exp_src;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    intf_rr_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d,
                                 input logic [3:0] l, input logic rdy);
        @(negedge clk);
        req       = r;
        req_data  = d;
        req_lock  = l;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [3:0] exp_ack, input logic chk_payload,
                               input logic [1:0] exp_src, input logic [7:0] exp_data);
        vec_count++;
        if (out_valid !== exp_valid) begin
            miss_count++;
            $display("[TB] FAIL %s out_valid got %0b want %0b", name, out_valid, exp_valid);
        end
        if (ack !== exp_ack) begin
            miss_count++;
            $display("[TB] FAIL %s ack got %b want %b", name, ack, exp_ack);
        end
        if (chk_payload) begin
            if (out_src !== exp_src) begin
                miss_count++;
                $display("[TB] FAIL %s out_src got %0d want %0d", name, out_src, exp_src);
            end
            if (out_data !== exp_data) begin
                miss_count++;
                $display("[TB] FAIL %s out_data got %h want %h", name, out_data, exp_data);
            end
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req       = '0;
        req_data  = BASE_DATA;
        req_lock  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  lock_second;

        // Single request to 2, wrap from ptr=3 over req=0011, then requester 1.
        vecs[0] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00};
        vecs[1] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA5};
        vecs[2] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 8'hA5};
        vecs[3] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 2'd2, 8'hA5};
        vecs[4] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h10};
        vecs[5] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h10};
        vecs[6] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h21};
        vecs[7] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h21};

        rst       = 1'b1;
        req       = 4'b1111;
        req_data  = BASE_DATA;
        req_lock  = '0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_state", 1'b0, 4'b0000, 1'b1, 2'd0, 8'h00);
        doReset();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].req, BASE_DATA, 4'b0000, vecs[i].out_ready);
            checkOutput($sformatf("table_%0d", i), vecs[i].exp_valid, vecs[i].exp_ack,
                        1'b1, vecs[i].exp_src, vecs[i].exp_data);
        end

        // All requesters held high: grants 0,1,2,3,0, one every two cycles.
        doReset();
        for (int g = 0; g < 5; g++) begin
            applyStimulus(4'b1111, BASE_DATA, 4'b0000, 1'b1);
            checkOutput($sformatf("all_idle_%0d", g), 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
            applyStimulus(4'b1111, BASE_DATA, 4'b0000, 1'b1);
            checkOutput($sformatf("all_grant_%0d", g), 1'b1, 4'b0001 << (g % 4), 1'b1,
                        2'(g % 4), word_of[g % 4]);
        end

        // Backpressure on requester 1 while its data keeps changing.
        doReset();
        applyStimulus(4'b0010, BASE_DATA, 4'b0000, 1'b0);
        checkOutput("bp_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b0010, BASE_DATA, 4'b0000, 1'b0);
        checkOutput("bp_grant", 1'b1, 4'b0000, 1'b1, 2'd1, 8'h21);
        for (int i = 0; i < 5; i++) begin
            d = BASE_DATA;
            d[15:8] = 8'h40 + 8'(i);
            applyStimulus(4'b0010, d, 4'b0000, 1'b0);
            checkOutput($sformatf("bp_hold_%0d", i), 1'b1, 4'b0000, 1'b1, 2'd1, 8'h21);
        end
        applyStimulus(4'b0010, BASE_DATA, 4'b0000, 1'b1);
        checkOutput("bp_release", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21);
        applyStimulus(4'b0000, BASE_DATA, 4'b0000, 1'b1);
        checkOutput("bp_after", 1'b0, 4'b0000, 1'b1, 2'd1, 8'h21);

        // Reset while requester 3's word is in flight; ptr was 2 beforehand.
        applyStimulus(4'b1000, BASE_DATA, 4'b0000, 1'b0);
        checkOutput("mid_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b1000, BASE_DATA, 4'b0000, 1'b0);
        checkOutput("mid_busy", 1'b1, 4'b0000, 1'b1, 2'd3, 8'h3C);
        @(negedge clk);
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        checkOutput("mid_reset_async", 1'b0, 4'b0000, 1'b1, 2'd0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("mid_reset_held", 1'b0, 4'b0000, 1'b1, 2'd0, 8'h00);
        rst = 1'b0;
        req = 4'b1010;
        applyStimulus(4'b1010, BASE_DATA, 4'b0000, 1'b1);
        checkOutput("mid_ptr_zero", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21);

        // Lock hint on requester 2 after ptr is moved to 2.
`ifdef INTF_ARB_LOCK_EN
        lock_second = 2'd2;
`else
        lock_second = 2'd1;
`endif
        doReset();
        applyStimulus(4'b0010, BASE_DATA, 4'b0000, 1'b1);
        checkOutput("lock_pre_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b0010, BASE_DATA, 4'b0000, 1'b1);
        checkOutput("lock_pre_grant", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21);
        applyStimulus(4'b0110, BASE_DATA, 4'b0100, 1'b1);
        checkOutput("lock_idle_a", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b0110, BASE_DATA, 4'b0100, 1'b1);
        checkOutput("lock_first", 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5);
        applyStimulus(4'b0110, BASE_DATA, 4'b0100, 1'b1);
        checkOutput("lock_idle_b", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b0110, BASE_DATA, 4'b0100, 1'b1);
        checkOutput("lock_second", 1'b1, 4'b0001 << lock_second, 1'b1,
                    lock_second, word_of[lock_second]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
